// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: opcodes, instruction field positions and the entry type.
// PIPE_XLEN (default 32) sets the entry field width; keep it equal to XLEN of pipe_stage_buf.
`ifndef PIPE_XLEN
`define PIPE_XLEN 32
`endif

package pipe_pkg;

    localparam int XLEN_DEF = `PIPE_XLEN;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         instr;
        logic [XLEN_DEF-1:0] target;
        logic [XLEN_DEF-1:0] data;
    } stage_entry_t;

endpackage

// File: rtl/pipe_stage_buf_wb_decode.sv
// Combinational writeback decode of one instruction; all outputs read as a bubble when valid is low.
module wb_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  alu_op,
    output logic        rd_is_0,
    output logic        wen,
    output logic        modifies_rd,
    output logic        lw,
    output logic        jal,
    output logic        setx
);

    logic is_rtype, is_addi;
    logic unused_instr_bits;

    assign unused_instr_bits = ^{instr[RD_LO-1:ALU_HI+1], instr[ALU_LO-1:0]};

    always_comb begin
        opcode = '0;
        rd     = '0;
        alu_op = '0;
        if (valid) begin
            opcode = instr[OPC_HI:OPC_LO];
            rd     = instr[RD_HI:RD_LO];
            alu_op = instr[ALU_HI:ALU_LO];
        end
        is_rtype    = valid && (opcode == OP_RTYPE);
        is_addi     = valid && (opcode == OP_ADDI);
        lw          = valid && (opcode == OP_LW);
        jal         = valid && (opcode == OP_JAL);
        setx        = valid && (opcode == OP_SETX);
        // jal writes the link register but does not produce an rd result
        modifies_rd = is_rtype | is_addi | lw | setx;
        wen         = modifies_rd | jal;
        rd_is_0     = (rd == 5'd0);
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready circular pipeline buffer with head-entry writeback decode and synchronous flush.
// Optional PIPE_STAGE_STALL_CNT_EN adds a saturating stall_cycles counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            rise,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] target_in,
    input  logic [XLEN-1:0] data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] target_out,
    output logic [XLEN-1:0] data_out,
    output logic [4:0]      opcode_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      alu_op_out,
    output logic            rd_is_0,
    output logic            wen,
    output logic            modifies_rd,
    output logic            lw_out,
    output logic            jal_out,
    output logic            setx_out,
    output logic [PTR_W:0]  count
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    stage_entry_t           mem_q [DEPTH];
    stage_entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   push, pop;
    stage_entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            // a push in the flush cycle is dropped along with the stored entries
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = '{pc: pc_in, instr: instr_in, target: target_in, data: data_in};
                wptr_d        = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge rise) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head       = mem_q[rptr_q];
    assign pc_out     = out_valid ? head.pc     : '0;
    assign target_out = out_valid ? head.target : '0;
    assign data_out   = out_valid ? head.data   : '0;

    wb_decode u_wb_decode (
        .instr       (head.instr),
        .valid       (out_valid),
        .opcode      (opcode_out),
        .rd          (rd_out),
        .alu_op      (alu_op_out),
        .rd_is_0     (rd_is_0),
        .wen         (wen),
        .modifies_rd (modifies_rd),
        .lw          (lw_out),
        .jal         (jal_out),
        .setx        (setx_out)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [32:0] stall_sum;

    always_comb begin
        stall_sum = {1'b0, stall_q}
                  + 33'(in_valid && !in_ready)
                  + 33'(out_valid && !out_ready);
        stall_d   = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
    end

    always_ff @(posedge rise) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH=2, XLEN=32).
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic        rise = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] pc_in, instr_in, target_in, data_in;
    logic [31:0] pc_out, target_out, data_out;
    logic [4:0]  opcode_out, rd_out, alu_op_out;
    logic        rd_is_0, wen, modifies_rd, lw_out, jal_out, setx_out;
    logic [1:0]  count;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] I_LW   = 32'h40C0_0000; // lw   rd=3
    localparam logic [31:0] I_ADDI = 32'h2840_000C; // addi rd=1 alu_op=3
    localparam logic [31:0] I_JAL  = 32'h1FC0_0000; // jal  rd=31
    localparam logic [31:0] I_RTYP = 32'h0080_0000; // rtype rd=2
    localparam logic [31:0] I_SETX = 32'hA800_0000; // setx rd=0 base

    pipe_stage_buf #(.XLEN(32), .DEPTH(2)) dut (
        .rise        (rise),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .target_in   (target_in),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_out      (pc_out),
        .target_out  (target_out),
        .data_out    (data_out),
        .opcode_out  (opcode_out),
        .rd_out      (rd_out),
        .alu_op_out  (alu_op_out),
        .rd_is_0     (rd_is_0),
        .wen         (wen),
        .modifies_rd (modifies_rd),
        .lw_out      (lw_out),
        .jal_out     (jal_out),
        .setx_out    (setx_out),
        .count       (count)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 rise = ~rise;

    task automatic step();
        @(posedge rise);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = ins;
        target_in = pc + 32'h100;
        data_in   = ~pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // reset and empty
        step(); step();
        reset = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_rd_is_0", 64'(rd_is_0), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_pc_out", 64'(pc_out), 64'd0);

        // single pass, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'h10, I_LW);
        chk("sp_no_bypass", 64'(out_valid), 64'd0);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("sp_out_valid", 64'(out_valid), 64'd1);
        chk("sp_lw", 64'(lw_out), 64'd1);
        chk("sp_wen", 64'(wen), 64'd1);
        chk("sp_mod_rd", 64'(modifies_rd), 64'd1);
        chk("sp_rd", 64'(rd_out), 64'd3);
        chk("sp_opcode", 64'(opcode_out), 64'(OP_LW));
        chk("sp_pc", 64'(pc_out), 64'h10);
        chk("sp_target", 64'(target_out), 64'h110);
        chk("sp_data", 64'(data_out), 64'hFFFF_FFEF);
        chk("sp_rd_is_0", 64'(rd_is_0), 64'd0);
        step();
        chk("sp_drain", 64'(out_valid), 64'd0);

        // fill and backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h20, I_ADDI);
        step();
        drive(1'b1, 32'h24, I_JAL);
        step();
        chk("fill_count", 64'(count), 64'd2);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h28, I_RTYP);
        step();
        chk("full_count", 64'(count), 64'd2);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        chk("bp_addi_pc", 64'(pc_out), 64'h20);
        chk("bp_addi_alu", 64'(alu_op_out), 64'd3);
        chk("bp_addi_rd", 64'(rd_out), 64'd1);
        chk("bp_addi_mod", 64'(modifies_rd), 64'd1);
        step();
        chk("bp_jal_pc", 64'(pc_out), 64'h24);
        chk("bp_jal_flag", 64'(jal_out), 64'd1);
        chk("bp_jal_wen", 64'(wen), 64'd1);
        chk("bp_jal_mod", 64'(modifies_rd), 64'd0);
        chk("bp_jal_rd", 64'(rd_out), 64'd31);
        step();
        chk("bp_third_dropped", 64'(out_valid), 64'd0);

        // streaming across pointer wrap with concurrent push/pop
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), I_SETX | (32'(i) << 22));
            step();
            chk($sformatf("st_pc%0d", i), 64'(pc_out), 64'(i));
            chk($sformatf("st_cnt%0d", i), 64'(count), 64'd1);
            chk($sformatf("st_rd%0d", i), 64'(rd_out), 64'(i));
        end
        chk("st_setx", 64'(setx_out), 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("st_empty", 64'(count), 64'd0);

        // flush while full with in_valid
        out_ready = 1'b0;
        drive(1'b1, 32'h40, I_ADDI);
        step();
        drive(1'b1, 32'h44, I_ADDI);
        step();
        chk("fl_pre_count", 64'(count), 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'h99, I_LW);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);

        // flush with a space free: the flush-cycle push must vanish
        drive(1'b1, 32'h60, I_ADDI);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h77, I_LW);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        chk("fl2_count", 64'(count), 64'd0);
        drive(1'b1, 32'h50, I_RTYP);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("fl2_count_after", 64'(count), 64'd1);
        chk("fl2_head_pc", 64'(pc_out), 64'h50);
        chk("fl2_rtype_rd", 64'(rd_out), 64'd2);

`ifdef PIPE_STAGE_STALL_CNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sc_reset", 64'(stall_cycles), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h80, I_ADDI);
        step();                 // count 0 -> 1, no stall
        step();                 // count 1: output stall +1
        for (int i = 0; i < 5; i++) step(); // full: +2 each
        chk("sc_full5", 64'(stall_cycles), 64'd11);
        flush = 1'b1;
        step();                 // still full this cycle: +2
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("sc_after_flush", 64'(stall_cycles), 64'd13);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sc_cleared", 64'(stall_cycles), 64'd0);
`endif

        // reset overrides a pending handshake
        out_ready = 1'b1;
        drive(1'b1, 32'hA0, I_LW);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_rd_is_0", 64'(rd_is_0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
